vga_scan_out: RTL and testbench

Raster timing generator and output stage for the Space Invaders video path. It generates the horizontal and vertical scan position that the sprite/playfield logic uses to produce a 4-bit color code. It then accepts the 12-bit RGB value returned by the color mapper and drives the VGA pins. Blanking and sync are delayed internally so they stay aligned with the pixel pipeline latency.

---
 rtl/vga_scan_out_if.sv | 27 ++
 rtl/vga_scan_out.sv | 184 ++++++++++++++++++
 tb/tb_vga_scan_out.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_out_if.sv
// Pixel-side bus of vga_scan_out: scan position and pulses out, mapped color in, VGA pins out.
interface vga_scan_out_if;
  logic        pix_en;
  logic [11:0] color_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic        line_start;
  logic        frame_start;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;

  modport master (
    input  pix_en, color_in,
    output x, y, active, line_start, frame_start,
    output vga_r, vga_g, vga_b, vga_hs, vga_vs
  );

  modport slave (
    output pix_en, color_in,
    input  x, y, active, line_start, frame_start,
    input  vga_r, vga_g, vga_b, vga_hs, vga_vs
  );
endinterface

// File: rtl/vga_scan_out.sv
// Raster timing generator and VGA output stage with blank/sync delayed to match the pixel pipeline.
// Optional feature: define VGA_TEST_PATTERN_EN to replace color_in with 8 vertical color bars.
module vga_scan_out #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scan_out_if.master bus
);

  localparam int unsigned CW      = 10;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CW-1:0]    hcount;
  logic [CW-1:0]    vcount;
  logic [CW-1:0]    hcount_nxt_c;
  logic [CW-1:0]    vcount_nxt_c;
  logic             h_wrap_c;
  logic             v_wrap_c;
  logic             active_c;
  logic             hs_raw_c;
  logic             vs_raw_c;

  logic             line_start_q;
  logic             frame_start_q;

  logic [PIPE_DELAY-1:0] act_pipe;
  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic             act_d_c;
  logic             hs_d_c;
  logic             vs_d_c;

  logic [RGB_W-1:0] pixel_src_c;
  logic [RGB_W-1:0] rgb_q;
  logic             hs_q;
  logic             vs_q;

  // Raster decode from the live counters.
  assign h_wrap_c = (hcount == H_LAST);
  assign v_wrap_c = (vcount == V_LAST);
  assign active_c = (hcount < H_VIS) && (vcount < V_VIS);
  assign hs_raw_c = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
  assign vs_raw_c = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));

  // Counter next state: hcount steps each tick, vcount steps on hcount wrap.
  always_comb begin
    hcount_nxt_c = hcount;
    vcount_nxt_c = vcount;
    if (bus.pix_en) begin
      if (h_wrap_c) begin
        hcount_nxt_c = '0;
        vcount_nxt_c = v_wrap_c ? '0 : vcount + CW'(1);
      end else begin
        hcount_nxt_c = hcount + CW'(1);
      end
    end
  end

  // Counters rest at the last position so the first tick lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= H_LAST;
      vcount <= V_LAST;
    end else begin
      hcount <= hcount_nxt_c;
      vcount <= vcount_nxt_c;
    end
  end

  // Pulses mark the clock after the wrapping tick and clear on any other clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= bus.pix_en && h_wrap_c;
      frame_start_q <= bus.pix_en && h_wrap_c && v_wrap_c;
    end
  end

  // Blank/sync delay line, shifting in at bit 0 and read from the top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_pipe <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
    end else if (bus.pix_en) begin
      act_pipe <= PIPE_DELAY'({act_pipe, active_c});
      hs_pipe  <= PIPE_DELAY'({hs_pipe, hs_raw_c});
      vs_pipe  <= PIPE_DELAY'({vs_pipe, vs_raw_c});
    end
  end

  assign act_d_c = act_pipe[PIPE_DELAY-1];
  assign hs_d_c  = hs_pipe[PIPE_DELAY-1];
  assign vs_d_c  = vs_pipe[PIPE_DELAY-1];

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W      = H_ACTIVE / 8;
  localparam int unsigned BAR_PIPE_W = 3 * PIPE_DELAY;

  logic [2:0]            bar_c;
  logic [2:0]            bar_d_c;
  logic [BAR_PIPE_W-1:0] bar_pipe;
  logic                  unused_color_in_c;

  function automatic logic [RGB_W-1:0] bar_color(input logic [2:0] bar);
    logic [RGB_W-1:0] rgb;
    case (bar)
      3'd0:    rgb = 12'hFFF;
      3'd1:    rgb = 12'hFF0;
      3'd2:    rgb = 12'h0FF;
      3'd3:    rgb = 12'h0F0;
      3'd4:    rgb = 12'hF0F;
      3'd5:    rgb = 12'hF00;
      3'd6:    rgb = 12'h00F;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  // Bar index rides the same delay line as blanking so it lines up with the delayed x.
  assign bar_c = 3'(hcount / CW'(BAR_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_pipe <= '0;
    end else if (bus.pix_en) begin
      bar_pipe <= BAR_PIPE_W'({bar_pipe, bar_c});
    end
  end

  assign bar_d_c           = bar_pipe[BAR_PIPE_W-1 -: 3];
  assign pixel_src_c       = bar_color(bar_d_c);
  assign unused_color_in_c = ^bus.color_in;
`else
  assign pixel_src_c = bus.color_in;
`endif

  // Pin register: blank forces black, syncs follow the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (bus.pix_en) begin
      rgb_q <= act_d_c ? pixel_src_c : '0;
      hs_q  <= hs_d_c;
      vs_q  <= vs_d_c;
    end
  end

  assign bus.x           = hcount;
  assign bus.y           = vcount;
  assign bus.active      = active_c;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.vga_r       = rgb_q[11:8];
  assign bus.vga_g       = rgb_q[7:4];
  assign bus.vga_b       = rgb_q[3:0];
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Randomized bench for vga_scan_out on a scaled raster, checked against a tick-count model.
module tb_vga_scan_out;

  localparam int HA  = 64;
  localparam int HFP = 8;
  localparam int HSY = 12;
  localparam int HBP = 12;
  localparam int VA  = 40;
  localparam int VFP = 3;
  localparam int VSY = 2;
  localparam int VBP = 5;
  localparam int PD  = 2;
  localparam int HT  = HA + HFP + HSY + HBP;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int FT  = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_scan_out_if bus();

  vga_scan_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .PIPE_DELAY(PD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int          total = 0;
  int          bad = 0;
  int          n = 0;
  logic [11:0] last_col = 12'h000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (tick %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  // Raster position after t pix_en ticks since reset; tick 0 is the reset rest position.
  function automatic int pos_x(input int t);
    return (t == 0) ? HT - 1 : ((t - 1) % FT) % HT;
  endfunction

  function automatic int pos_y(input int t);
    return (t == 0) ? VT - 1 : ((t - 1) % FT) / HT;
  endfunction

`ifdef VGA_TEST_PATTERN_EN
  function automatic logic [11:0] bar_rgb(input int xx);
    case (xx / (HA / 8))
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction
`endif

  task automatic check_all(input bit en);
    int          t0;
    int          xx;
    int          yy;
    bit          act;
    logic [11:0] rgb_e;
    bit          hs_e;
    bit          vs_e;
    check("x", 32'(bus.x), 32'(pos_x(n)));
    check("y", 32'(bus.y), 32'(pos_y(n)));
    check("active", 32'(bus.active), 32'(pos_x(n) < HA && pos_y(n) < VA));
    check("line_start", 32'(bus.line_start), 32'(en && pos_x(n) == 0));
    check("frame_start", 32'(bus.frame_start), 32'(en && pos_x(n) == 0 && pos_y(n) == 0));
    // Pins show the pixel presented PD+1 ticks ago.
    t0 = n - (PD + 1);
    if (t0 < 1) begin
      rgb_e = 12'h000;
      hs_e  = 1'b1;
      vs_e  = 1'b1;
    end else begin
      xx  = pos_x(t0);
      yy  = pos_y(t0);
      act = (xx < HA) && (yy < VA);
`ifdef VGA_TEST_PATTERN_EN
      rgb_e = act ? bar_rgb(xx) : 12'h000;
`else
      rgb_e = act ? last_col : 12'h000;
`endif
      hs_e = !(xx >= HA + HFP && xx < HA + HFP + HSY);
      vs_e = !(yy >= VA + VFP && yy < VA + VFP + VSY);
    end
    check("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(rgb_e));
    check("vga_hs", 32'(bus.vga_hs), 32'(hs_e));
    check("vga_vs", 32'(bus.vga_vs), 32'(vs_e));
  endtask

  task automatic step(input bit en, input logic [11:0] col);
    bus.pix_en   = en;
    bus.color_in = col;
    @(posedge clk);
    #1;
    if (en) begin
      n++;
      last_col = col;
    end
    check_all(en);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int cx;
    int cy;
    bit found;

    bus.pix_en   = 1'b0;
    bus.color_in = 12'h000;
    #12;
    n = 0;
    check_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous pix_en over two frames, color_in modelled as a 2-tick mapper of {x,y,A}.
    for (int i = 0; i < 2 * FT + 50; i++) begin
      t = n + 1 - (PD + 1);
      cx = (t < 1) ? 0 : pos_x(t);
      cy = (t < 1) ? 0 : pos_y(t);
      step(1'b1, {4'(cx), 4'(cy), 4'hA});
    end

    // pix_en one clock in four with random colors.
    for (int i = 0; i < 4000; i++) begin
      step((i % 4) == 0, 12'($urandom));
    end

    // Run to (30,20), then pull reset mid-frame.
    found = 1'b0;
    for (int i = 0; i < FT + 10 && !found; i++) begin
      step(1'b1, 12'($urandom));
      if (bus.x == 10'd30 && bus.y == 10'd20) found = 1'b1;
    end
    check("seek_30_20", 32'(found), 32'(1));

    #2;
    rst_n = 1'b0;
    n = 0;
    last_col = 12'h000;
    #1;
    check_all(1'b0);
    bus.pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all(1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random pix_en gating and random colors after the restart.
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 1) == 1, 12'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
